// File: rtl/timer_digit_entry.sv
// timer_digit_entry: keypad digit entry for the microwave timer.
// Debounces a multi-hot key bank (highest index wins), accepts each physical
// press exactly once, and shifts accepted digits into an NUM_DIGITS-deep BCD
// register with the newest digit in position 0.
// Optional build macro: TIMER_ENTRY_SECFMT_EN -- rejects any accept that
// would move a value above 5 into digit 1 (tens of seconds) and reports the
// rejection on o_sec_err.
module timer_digit_entry #(
  parameter int NUM_DIGITS      = 3,
  parameter int NUM_KEYS        = 10,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_enable,
  input  logic                              i_clear,
  input  logic [NUM_KEYS-1:0]               i_keys,
  output logic [4*NUM_DIGITS-1:0]           o_digits,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   o_digit_count,
  output logic                              o_loaded,
  output logic                              o_digit_pulse,
  output logic                              o_overflow
`ifdef TIMER_ENTRY_SECFMT_EN
  ,
  output logic                              o_sec_err
`endif
);

  localparam int               CW        = $clog2(NUM_DIGITS + 1);
  localparam int               CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [3:0]       CODE_NONE = 4'hF;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]    CNT_FULL  = CW'(NUM_DIGITS);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PRESS_DB = 2'd1,
    S_HELD     = 2'd2,
    S_REL_DB   = 2'd3
  } state_t;

  // Highest asserted key index, or CODE_NONE when the bank is idle.
  function automatic logic [3:0] encode_keys(input logic [NUM_KEYS-1:0] keys);
    logic [3:0] code;
    code = CODE_NONE;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (keys[i]) begin
        code = 4'(i);
      end else begin
        code = code;
      end
    end
    return code;
  endfunction

  logic [3:0]              r_code_q;
  state_t                  r_state;
  logic [3:0]              r_cand;
  logic [CNT_W-1:0]        r_cnt;
  logic [4*NUM_DIGITS-1:0] r_digits;
  logic [CW-1:0]           r_count;
  logic                    r_loaded;
  logic                    r_pulse;
  logic                    r_overflow;

  state_t                  w_state_nxt;
  logic [3:0]              w_cand_nxt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic                    w_accept;
  logic                    w_sec_bad;
  logic                    w_take;
  logic                    w_msb_nz;
  logic [4*NUM_DIGITS-1:0] w_shifted;
  logic [CW-1:0]           w_count_inc;

  // Register the encoded key bank once so every FSM decision sees a stable code.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_code_q <= CODE_NONE;
    end else begin
      r_code_q <= encode_keys(i_keys);
    end
  end

  // FSM state, press candidate and debounce counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cand  <= 4'd0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cand  <= w_cand_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Debounce decisions: a press needs a run of identical codes, a release a
  // run of idle samples; any disagreement abandons the press attempt.
  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    if (!i_enable) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_code_q != CODE_NONE) begin
            w_state_nxt = S_PRESS_DB;
            w_cand_nxt  = r_code_q;
            w_cnt_nxt   = CNT_W'(1);
          end else begin
            w_cnt_nxt   = '0;
          end
        end
        S_PRESS_DB: begin
          if (r_code_q == r_cand) begin
            if (r_cnt >= CNT_MAX) begin
              w_accept    = 1'b1;
              w_state_nxt = S_HELD;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
          end else begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end
        end
        S_HELD: begin
          // Any key held, even a different one, keeps us here.
          if (r_code_q == CODE_NONE) begin
            w_state_nxt = S_REL_DB;
            w_cnt_nxt   = CNT_W'(1);
          end else begin
            w_state_nxt = S_HELD;
          end
        end
        S_REL_DB: begin
          if (r_code_q == CODE_NONE) begin
            if (r_cnt >= CNT_MAX) begin
              w_state_nxt = S_IDLE;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
          end else begin
            w_state_nxt = S_HELD;
            w_cnt_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Shift/overflow/format helpers for the digit register.
  always_comb begin
    w_shifted   = {r_digits[4*NUM_DIGITS-5:0], r_cand};
    w_msb_nz    = |r_digits[4*NUM_DIGITS-1 -: 4];
    w_count_inc = (r_count == CNT_FULL) ? r_count : (r_count + CW'(1));
`ifdef TIMER_ENTRY_SECFMT_EN
    // Current digit 0 becomes tens of seconds after the shift.
    w_sec_bad   = (r_digits[3:0] > 4'd5);
`else
    w_sec_bad   = 1'b0;
`endif
    w_take      = w_accept & ~w_sec_bad;
  end

  // Digit register, entry count and strobes; clear wins over a same-edge accept.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_digits   <= '0;
      r_count    <= '0;
      r_loaded   <= 1'b0;
      r_pulse    <= 1'b0;
      r_overflow <= 1'b0;
    end else if (i_clear) begin
      r_digits   <= '0;
      r_count    <= '0;
      r_loaded   <= 1'b0;
      r_pulse    <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_take) begin
      r_digits   <= w_shifted;
      r_count    <= w_count_inc;
      r_loaded   <= 1'b1;
      r_pulse    <= 1'b1;
      r_overflow <= w_msb_nz;
    end else begin
      r_pulse    <= 1'b0;
      r_overflow <= 1'b0;
    end
  end

`ifdef TIMER_ENTRY_SECFMT_EN
  logic r_sec_err;

  // One-cycle flag for an accept rejected by the seconds-format rule.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sec_err <= 1'b0;
    end else if (i_clear) begin
      r_sec_err <= 1'b0;
    end else begin
      r_sec_err <= w_accept & w_sec_bad;
    end
  end

  assign o_sec_err = r_sec_err;
`endif

  assign o_digits      = r_digits;
  assign o_digit_count = r_count;
  assign o_loaded      = r_loaded;
  assign o_digit_pulse = r_pulse;
  assign o_overflow    = r_overflow;

endmodule

// File: tb/tb_timer_digit_entry.sv
// Self-checking bench for timer_digit_entry: hand sequences, a vector table
// and randomized key traffic checked against a run-length reference model.
module tb_timer_digit_entry;

  localparam int N = 3;
  localparam int K = 10;
  localparam int D = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic           clr;
  logic [K-1:0]   keys;
  logic [4*N-1:0] digits;
  logic [1:0]     dcount;
  logic           loaded;
  logic           pulse;
  logic           ovf;
`ifdef TIMER_ENTRY_SECFMT_EN
  logic           sec_err;
`endif

  always #5 clk = ~clk;

  timer_digit_entry #(
    .NUM_DIGITS(N), .NUM_KEYS(K), .DEBOUNCE_CYCLES(D)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_clear(clr), .i_keys(keys),
    .o_digits(digits), .o_digit_count(dcount), .o_loaded(loaded),
    .o_digit_pulse(pulse), .o_overflow(ovf)
`ifdef TIMER_ENTRY_SECFMT_EN
    , .o_sec_err(sec_err)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model: value held as a plain decimal number, debounce as run lengths.
  int m_value, m_count, m_code, m_run_len, m_run_code, m_streak;
  bit m_loaded, m_pulse, m_ovf, m_sec, m_armed;

  function automatic int enc(input logic [K-1:0] k);
    for (int i = K - 1; i >= 0; i--) if (k[i]) return i;
    return 15;
  endfunction

  function automatic int pow10(input int e);
    int p = 1;
    for (int i = 0; i < e; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [4*N-1:0] to_bcd(input int v);
    logic [4*N-1:0] r;
    for (int k = 0; k < N; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    bit acc = 1'b0;
    int cand = 0;
    bit sec_rule = 1'b0;
`ifdef TIMER_ENTRY_SECFMT_EN
    sec_rule = 1'b1;
`endif
    if (rst) begin
      m_value = 0; m_count = 0; m_loaded = 0; m_pulse = 0; m_ovf = 0; m_sec = 0;
      m_code = 15; m_armed = 1; m_run_len = 0; m_streak = 0;
      return;
    end
    if (!en) begin
      m_armed = 1; m_run_len = 0;
    end else if (m_armed) begin
      if (m_run_len == 0) begin
        if (m_code != 15) begin m_run_code = m_code; m_run_len = 1; end
      end else if (m_code == m_run_code) begin
        m_run_len++;
        if (m_run_len == D + 1) begin
          acc = 1; cand = m_run_code; m_armed = 0; m_streak = 0; m_run_len = 0;
        end
      end else begin
        m_run_len = 0;
      end
    end else begin
      if (m_code == 15) begin
        m_streak++;
        if (m_streak == D + 1) begin m_armed = 1; m_streak = 0; m_run_len = 0; end
      end else begin
        m_streak = 0;
      end
    end
    m_pulse = 0; m_ovf = 0; m_sec = 0;
    if (clr) begin
      m_value = 0; m_count = 0; m_loaded = 0;
    end else if (acc) begin
      if (sec_rule && (m_value % 10) > 5) begin
        m_sec = 1;
      end else begin
        m_ovf   = (m_value >= pow10(N - 1));
        m_value = (m_value * 10 + cand) % pow10(N);
        m_count = (m_count < N) ? m_count + 1 : N;
        m_loaded = 1; m_pulse = 1;
      end
    end
    m_code = enc(keys);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("digits", 64'(digits), 64'(to_bcd(m_value)));
    check("count", 64'(dcount), 64'(m_count));
    check("loaded", 64'(loaded), 64'(m_loaded));
    check("pulse", 64'(pulse), 64'(m_pulse));
    check("overflow", 64'(ovf), 64'(m_ovf));
`ifdef TIMER_ENTRY_SECFMT_EN
    check("sec_err", 64'(sec_err), 64'(m_sec));
`endif
  endtask

  // Hold the given keys for n cycles, counting digit and sec strobes.
  task automatic run(input logic [K-1:0] k, input int n, output int np, output int ns);
    keys = k; np = 0; ns = 0;
    for (int c = 0; c < n; c++) begin
      tick();
      if (pulse) np++;
`ifdef TIMER_ENTRY_SECFMT_EN
      if (sec_err) ns++;
`endif
    end
  endtask

  typedef struct {
    logic [K-1:0]   keys;
    logic           clr;
    int             cyc;
    logic [4*N-1:0] e_dig;
    int             e_cnt;
    logic           e_ld;
    int             e_pulses;
    int             e_ovfs;
  } vec_t;

  vec_t tbl[24];

  initial begin
    int first, np, ns, no;
    tbl[0]  = '{10'h000, 1'b0, 8, 12'h003, 1, 1'b1, 0, 0};
    tbl[1]  = '{10'h000, 1'b1, 1, 12'h000, 0, 1'b0, 0, 0};
    tbl[2]  = '{10'h002, 1'b0, 8, 12'h001, 1, 1'b1, 1, 0};
    tbl[3]  = '{10'h000, 1'b0, 8, 12'h001, 1, 1'b1, 0, 0};
    tbl[4]  = '{10'h004, 1'b0, 8, 12'h012, 2, 1'b1, 1, 0};
    tbl[5]  = '{10'h000, 1'b0, 8, 12'h012, 2, 1'b1, 0, 0};
    tbl[6]  = '{10'h008, 1'b0, 8, 12'h123, 3, 1'b1, 1, 0};
    tbl[7]  = '{10'h000, 1'b0, 8, 12'h123, 3, 1'b1, 0, 0};
    tbl[8]  = '{10'h010, 1'b0, 8, 12'h234, 3, 1'b1, 1, 1};
    tbl[9]  = '{10'h000, 1'b0, 8, 12'h234, 3, 1'b1, 0, 0};
    tbl[10] = '{10'h000, 1'b1, 1, 12'h000, 0, 1'b0, 0, 0};
    tbl[11] = '{10'h020, 1'b0, 3, 12'h000, 0, 1'b0, 0, 0};
    tbl[12] = '{10'h000, 1'b0, 1, 12'h000, 0, 1'b0, 0, 0};
    tbl[13] = '{10'h020, 1'b0, 8, 12'h005, 1, 1'b1, 1, 0};
    tbl[14] = '{10'h000, 1'b0, 8, 12'h005, 1, 1'b1, 0, 0};
    tbl[15] = '{10'h084, 1'b0, 8, 12'h057, 2, 1'b1, 1, 0};
    tbl[16] = '{10'h004, 1'b0, 8, 12'h057, 2, 1'b1, 0, 0};
    tbl[17] = '{10'h000, 1'b0, 8, 12'h057, 2, 1'b1, 0, 0};
    tbl[18] = '{10'h200, 1'b0, 5, 12'h057, 2, 1'b1, 0, 0};
    tbl[19] = '{10'h200, 1'b1, 1, 12'h000, 0, 1'b0, 0, 0};
    tbl[20] = '{10'h200, 1'b0, 6, 12'h000, 0, 1'b0, 0, 0};
    tbl[21] = '{10'h000, 1'b0, 8, 12'h000, 0, 1'b0, 0, 0};
    tbl[22] = '{10'h200, 1'b0, 8, 12'h009, 1, 1'b1, 1, 0};
    tbl[23] = '{10'h000, 1'b0, 8, 12'h009, 1, 1'b1, 0, 0};

    // Reset state.
    rst = 1'b1; en = 1'b1; clr = 1'b0; keys = '0;
    tick(); tick();
    check("reset_digits", 64'(digits), 64'h0);
    check("reset_count", 64'(dcount), 64'h0);
    check("reset_loaded", 64'(loaded), 64'h0);
    check("reset_pulse", 64'(pulse), 64'h0);
    rst = 1'b0;

    // Latency: key 3 held from before edge 0, accept expected at edge 5.
    keys = 10'h008; first = -1; np = 0;
    tick();
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (pulse) begin np++; if (first < 0) first = e; end
    end
    check("latency_edge", 64'(first), 64'd5);
    check("latency_pulses", 64'(np), 64'd1);
    check("latency_digits", 64'(digits), 64'h003);

    // Vector table.
    for (int r = 0; r < 24; r++) begin
      keys = tbl[r].keys; clr = tbl[r].clr; np = 0; no = 0;
      for (int c = 0; c < tbl[r].cyc; c++) begin
        tick();
        if (pulse) np++;
        if (ovf) no++;
        clr = 1'b0;
      end
      check($sformatf("row%0d_digits", r), 64'(digits), 64'(tbl[r].e_dig));
      check($sformatf("row%0d_count", r), 64'(dcount), 64'(tbl[r].e_cnt));
      check($sformatf("row%0d_loaded", r), 64'(loaded), 64'(tbl[r].e_ld));
      check($sformatf("row%0d_pulses", r), 64'(np), 64'(tbl[r].e_pulses));
      check($sformatf("row%0d_ovfs", r), 64'(no), 64'(tbl[r].e_ovfs));
    end

    // Enable dropped during a press: nothing accepted, digits kept.
    begin
      int tot = 0;
      run(10'h040, 3, np, ns); tot += np;
      en = 1'b0;
      run(10'h040, 4, np, ns); tot += np;
      en = 1'b1;
      run(10'h000, 8, np, ns); tot += np;
      check("enable_pulses", 64'(tot), 64'd0);
      check("enable_digits", 64'(digits), 64'h009);
      check("enable_count", 64'(dcount), 64'd1);
    end

`ifdef TIMER_ENTRY_SECFMT_EN
    // Seconds format: 1 then 7 is fine, a third digit would put 7 in the tens.
    clr = 1'b1; run(10'h000, 1, np, ns); clr = 1'b0;
    run(10'h002, 8, np, ns); run(10'h000, 8, np, ns);
    run(10'h080, 8, np, ns); run(10'h000, 8, np, ns);
    check("secfmt_digits_17", 64'(digits), 64'h017);
    run(10'h004, 8, np, ns);
    check("secfmt_pulses", 64'(np), 64'd0);
    check("secfmt_err", 64'(ns), 64'd1);
    check("secfmt_digits", 64'(digits), 64'h017);
    run(10'h000, 8, np, ns);
`endif

    // Randomized key traffic against the reference model.
    for (int r = 0; r < 400; r++) begin
      int sel, len;
      logic [K-1:0] k;
      sel = $urandom_range(0, 9);
      if (sel < 4)      k = '0;
      else if (sel < 8) k = K'(1) << $urandom_range(0, K - 1);
      else              k = K'($urandom & 32'h3FF);
      len = $urandom_range(1, 12);
      en  = ($urandom_range(0, 29) != 0);
      clr = ($urandom_range(0, 39) == 0);
      keys = k;
      for (int c = 0; c < len; c++) begin
        tick();
        clr = 1'b0;
      end
    end
    en = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
